// File: rtl/otter_cache_pkg.sv
`default_nettype none
// ============================================================================
// otter_cache_pkg : shared types, width helpers and byte-merge for the cache
// Revision 1.0
// ============================================================================
package otter_cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } cache_state_t;

  function automatic int calc_offset_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int calc_index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int calc_tag_w(input int num_sets, input int words_per_line);
    return 32 - 2 - $clog2(words_per_line) - $clog2(num_sets);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[b*8 +: 8] = be[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/otter_cache_lru.sv
`default_nettype none
// ============================================================================
// otter_cache_lru : per-set true-LRU age counters, hit update, victim select
// Revision 1.0
// ============================================================================
module otter_cache_lru
  import otter_cache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 2,
  localparam int INDEX_W = calc_index_w(NUM_SETS),
  localparam int WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  idx,
  input  logic [NUM_WAYS-1:0] valid,
  input  logic                hit_en,
  input  logic [WAY_W-1:0]    hit_way,
  input  logic                fill_en,
  input  logic [WAY_W-1:0]    fill_way,
  output logic [WAY_W-1:0]    victim
);

  logic [WAY_W-1:0] age_q [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0] age_d [NUM_WAYS];
  logic [WAY_W-1:0] max_age;
  logic             found_invalid;

  // A freshly filled way is parked at the oldest age so the retry hit
  // promotes it over every other way, keeping the ages a permutation.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      age_d[w] = age_q[idx][w];
      if (hit_en) begin
        if (WAY_W'(w) == hit_way) begin
          age_d[w] = '0;
        end else if (age_q[idx][w] < age_q[idx][hit_way]) begin
          age_d[w] = age_q[idx][w] + 1'b1;
        end
      end else if (fill_en && WAY_W'(w) == fill_way) begin
        age_d[w] = '1;
      end
    end
  end

  always_comb begin
    found_invalid = 1'b0;
    victim        = '0;
    max_age       = age_q[idx][0];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found_invalid && !valid[w]) begin
        found_invalid = 1'b1;
        victim        = WAY_W'(w);
      end
    end
    if (!found_invalid) begin
      for (int w = 1; w < NUM_WAYS; w++) begin
        if (age_q[idx][w] > max_age) begin
          max_age = age_q[idx][w];
          victim  = WAY_W'(w);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          age_q[s][w] <= '0;
        end
      end
    end else if (hit_en || fill_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        age_q[idx][w] <= age_d[w];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/otter_sa_cache.sv
`default_nettype none
// ============================================================================
// otter_sa_cache : N-way set-associative write-back data cache with miss FSM
// Revision 1.0
// ============================================================================
module otter_sa_cache
  import otter_cache_pkg::*;
#(
  parameter int NUM_SETS       = 8,
  parameter int NUM_WAYS       = 2,
  parameter int WORDS_PER_LINE = 8,
  parameter int LINE_W         = 32 * WORDS_PER_LINE
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int OFFSET_W = calc_offset_w(WORDS_PER_LINE);
  localparam int INDEX_W  = calc_index_w(NUM_SETS);
  localparam int TAG_W    = calc_tag_w(NUM_SETS, WORDS_PER_LINE);
  localparam int WAY_W    = $clog2(NUM_WAYS);
  localparam int LOW_W    = OFFSET_W + 2;

  cache_state_t     state_q;
  logic [31:2]      addr_q;
  logic [31:0]      wdata_q;
  logic             we_q;
  logic [3:0]       be_q;
  logic [WAY_W-1:0] victim_q;

  logic [LINE_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];

  logic [OFFSET_W-1:0] off;
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    lru_victim;
  logic [LINE_W-1:0]   hit_line;
  logic [31:0]         hit_word;
  logic                data_we;
  logic                tag_we;
  logic [WAY_W-1:0]    wr_way;
  logic [LINE_W-1:0]   wr_line;
  logic                lru_hit_en;
  logic [NUM_WAYS-1:0] set_valid;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign off       = addr_q[2 +: OFFSET_W];
  assign idx       = addr_q[LOW_W +: INDEX_W];
  assign tag       = addr_q[31 -: TAG_W];
  assign cpu_ready = (state_q == IDLE);
  assign set_valid = valid_q[idx];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_line   = data_q[idx][hit_way];
  assign hit_word   = hit_line[{off, 5'b0} +: 32];
  assign lru_hit_en = !RST && state_q == COMPARE && hit;

  // Single write port shared by write hits and line fills; a reset cycle
  // suppresses both so a coincident mem_ack leaves the arrays untouched.
  always_comb begin
    data_we = 1'b0;
    tag_we  = 1'b0;
    wr_way  = hit_way;
    wr_line = hit_line;
    if (!RST) begin
      if (state_q == COMPARE && hit && we_q) begin
        data_we = 1'b1;
        wr_line[{off, 5'b0} +: 32] = merge_bytes(hit_word, wdata_q, be_q);
      end else if (state_q == ALLOCATE && mem_ack) begin
        data_we = 1'b1;
        tag_we  = 1'b1;
        wr_way  = victim_q;
        wr_line = mem_rdata;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (data_we) data_q[idx][wr_way] <= wr_line;
    if (tag_we)  tag_q[idx][wr_way]  <= tag;
  end

  otter_cache_lru #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_lru (
    .clk      (CLK),
    .rst      (RST),
    .idx      (idx),
    .valid    (set_valid),
    .hit_en   (lru_hit_en),
    .hit_way  (hit_way),
    .fill_en  (tag_we),
    .fill_way (victim_q),
    .victim   (lru_victim)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cpu_done  <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      victim_q  <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      cpu_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr[31:2];
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            be_q    <= cpu_be;
            state_q <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            cpu_done <= 1'b1;
            if (we_q) dirty_q[idx][hit_way] <= 1'b1;
            else      cpu_rdata <= hit_word;
            state_q <= IDLE;
          end else begin
            victim_q <= lru_victim;
            mem_req  <= 1'b1;
            if (valid_q[idx][lru_victim] && dirty_q[idx][lru_victim]) begin
              mem_we    <= 1'b1;
              mem_addr  <= {tag_q[idx][lru_victim], idx, {LOW_W{1'b0}}};
              mem_wdata <= data_q[idx][lru_victim];
              state_q   <= WRITEBACK;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= {tag, idx, {LOW_W{1'b0}}};
              state_q  <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            dirty_q[idx][victim_q] <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= {tag, idx, {LOW_W{1'b0}}};
            state_q  <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mem_ack) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            mem_req <= 1'b0;
            state_q <= COMPARE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_otter_sa_cache.sv
`default_nettype none
// ============================================================================
// tb_otter_sa_cache : scoreboard bench with a line-wide backing memory model
// Revision 1.0
// ============================================================================
module tb_otter_sa_cache;

  localparam int LINE_W = 256;

  logic              CLK = 1'b0;
  logic              RST;
  logic              cpu_req, cpu_we;
  logic [31:0]       cpu_addr, cpu_wdata;
  logic [3:0]        cpu_be;
  logic              cpu_ready, cpu_done;
  logic [31:0]       cpu_rdata;
  logic              mem_req, mem_we;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wdata, mem_rdata;
  logic              mem_ack;

  always #5 CLK = ~CLK;

  otter_sa_cache #(
    .NUM_SETS       (8),
    .NUM_WAYS       (2),
    .WORDS_PER_LINE (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_be    (cpu_be),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  typedef struct packed {
    logic        is_read;
    logic [31:0] rdata;
  } cpu_exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  widx;
    logic [31:0] wword;
  } mem_exp_t;

  cpu_exp_t          cpu_q[$];
  mem_exp_t          mem_q[$];
  logic [LINE_W-1:0] store [logic [31:0]];
  int                checks = 0;
  int                passes = 0;
  int                done_count = 0;
  int                mem_delay = 1;
  bit                mem_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Untouched lines hold each word's own byte address.
  function automatic logic [LINE_W-1:0] line_of(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    if (store.exists(a)) return store[a];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = {a[31:5], 3'(i), 2'b00};
    return l;
  endfunction

  task automatic expect_mem(input logic we, input logic [31:0] addr,
                            input logic [2:0] widx, input logic [31:0] wword);
    mem_exp_t e;
    e.we = we; e.addr = addr; e.widx = widx; e.wword = wword;
    mem_q.push_back(e);
  endtask

  initial begin : cpu_monitor
    cpu_exp_t e;
    forever begin
      @(negedge CLK);
      if (cpu_done === 1'b1) begin
        done_count++;
        if (cpu_q.size() == 0) begin
          checks++;
          $display("FAIL cpu_done_unexpected: got cpu_done=1 expected no completion");
        end else begin
          e = cpu_q.pop_front();
          if (e.is_read) check($sformatf("rdata_%0d", done_count), cpu_rdata, e.rdata);
        end
      end
    end
  end

  initial begin : mem_model
    mem_exp_t e;
    int n;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge CLK);
      if (mem_req === 1'b1 && RST !== 1'b1) begin
        if (mem_q.size() == 0) begin
          checks++;
          $display("FAIL mem_unexpected: got we=%b addr=%h expected no transaction", mem_we, mem_addr);
        end else begin
          e = mem_q.pop_front();
          check("mem_we", 32'(mem_we), 32'(e.we));
          check("mem_addr", mem_addr, e.addr);
          if (e.we) check("mem_wb_word", mem_wdata[e.widx*32 +: 32], e.wword);
        end
        n = 0;
        while ((n < mem_delay || mem_hold) && mem_req === 1'b1) begin
          @(negedge CLK);
          n++;
        end
        if (mem_req === 1'b1) begin
          if (mem_we) store[mem_addr] = mem_wdata;
          else        mem_rdata = line_of(mem_addr);
          mem_ack = 1'b1;
          @(negedge CLK);
          mem_ack   = 1'b0;
          mem_rdata = '0;
        end
      end
    end
  end

  // exp_lat > 0 checks hit latency; chk_ready checks cpu_ready stays low while busy.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata,
                        input int exp_lat, input bit chk_ready);
    cpu_exp_t e;
    int  n;
    bit  ready_leak;
    n = 0;
    while (cpu_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (cpu_ready !== 1'b1) begin
      checks++;
      $display("FAIL ready_timeout: got cpu_ready=%b expected 1", cpu_ready);
      return;
    end
    e.is_read = !we;
    e.rdata   = exp_rdata;
    cpu_q.push_back(e);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    n = 0;
    ready_leak = 1'b0;
    do begin
      @(negedge CLK);
      n++;
      if (cpu_done !== 1'b1 && cpu_ready === 1'b1) ready_leak = 1'b1;
    end while (cpu_done !== 1'b1 && n < 300);
    cpu_req = 1'b0;
    if (cpu_done !== 1'b1) begin
      checks++;
      $display("FAIL done_timeout: got no cpu_done for addr %h expected completion", addr);
      if (cpu_q.size() > 0) cpu_q.delete(cpu_q.size() - 1);
      return;
    end
    if (exp_lat > 0) check("hit_latency", 32'(n), 32'(exp_lat));
    if (chk_ready)   check("ready_low_during_miss", 32'(ready_leak), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    logic [LINE_W-1:0] l;
    int n;
    int dc;
    RST = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'h1000 + 32'(i);
    store[32'h40] = l;
    l = line_of(32'h80);
    l[31:0] = 32'h1000_1000;
    store[32'h80] = l;

    repeat (3) @(negedge CLK);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
    check("rst_cpu_done",  32'(cpu_done),  32'd0);
    check("rst_mem_req",   32'(mem_req),   32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  mem_addr,       32'd0);
    check("rst_cpu_rdata", cpu_rdata,      32'd0);
    RST = 1'b0;

    // cold miss then hit in the same line
    expect_mem(1'b0, 32'h40, 3'd0, 32'd0);
    access(1'b0, 32'h40, 32'd0, 4'h0, 32'h0000_1000, 0, 1'b0);
    access(1'b0, 32'h44, 32'd0, 4'h0, 32'h0000_1001, 2, 1'b0);

    // partial-byte write hit
    expect_mem(1'b0, 32'h80, 3'd0, 32'd0);
    access(1'b0, 32'h80, 32'd0, 4'h0, 32'h1000_1000, 0, 1'b0);
    access(1'b1, 32'h80, 32'hDEAD_BEEF, 4'b0011, 32'd0, 2, 1'b0);
    access(1'b0, 32'h80, 32'd0, 4'h0, 32'h1000_BEEF, 2, 1'b0);

    // three tags into set 1: dirty LRU line written back before the fill
    expect_mem(1'b0, 32'h20, 3'd0, 32'd0);
    access(1'b0, 32'h20, 32'd0, 4'h0, 32'h0000_0020, 0, 1'b0);
    access(1'b1, 32'h24, 32'hCAFE_F00D, 4'hF, 32'd0, 2, 1'b0);
    expect_mem(1'b0, 32'h120, 3'd0, 32'd0);
    access(1'b0, 32'h120, 32'd0, 4'h0, 32'h0000_0120, 0, 1'b0);
    expect_mem(1'b1, 32'h20, 3'd1, 32'hCAFE_F00D);
    expect_mem(1'b0, 32'h220, 3'd0, 32'd0);
    access(1'b0, 32'h220, 32'd0, 4'h0, 32'h0000_0220, 0, 1'b0);
    expect_mem(1'b0, 32'h20, 3'd0, 32'd0);
    access(1'b0, 32'h24, 32'd0, 4'h0, 32'hCAFE_F00D, 0, 1'b0);

    // LRU order in set 3: A, B, touch A, then C evicts B
    expect_mem(1'b0, 32'h60, 3'd0, 32'd0);
    access(1'b0, 32'h60, 32'd0, 4'h0, 32'h0000_0060, 0, 1'b0);
    expect_mem(1'b0, 32'h160, 3'd0, 32'd0);
    access(1'b0, 32'h160, 32'd0, 4'h0, 32'h0000_0160, 0, 1'b0);
    access(1'b0, 32'h60, 32'd0, 4'h0, 32'h0000_0060, 2, 1'b0);
    expect_mem(1'b0, 32'h260, 3'd0, 32'd0);
    access(1'b0, 32'h260, 32'd0, 4'h0, 32'h0000_0260, 0, 1'b0);
    access(1'b0, 32'h60, 32'd0, 4'h0, 32'h0000_0060, 2, 1'b0);

    // reset while a fill is outstanding
    mem_hold = 1'b1;
    expect_mem(1'b0, 32'hA0, 3'd0, 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hA0;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("alloc_started", 32'(mem_req), 32'd1);
    cpu_req = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_mem_req",   32'(mem_req),   32'd0);
    check("abort_cpu_ready", 32'(cpu_ready), 32'd1);
    mem_hold = 1'b0;
    expect_mem(1'b0, 32'h40, 3'd0, 32'd0);
    access(1'b0, 32'h40, 32'd0, 4'h0, 32'h0000_1000, 0, 1'b0);

    // slow memory: one completion, cpu_ready low throughout
    mem_delay = 10;
    dc = done_count;
    expect_mem(1'b0, 32'h2A0, 3'd0, 32'd0);
    access(1'b0, 32'h2A0, 32'd0, 4'h0, 32'h0000_02A0, 0, 1'b1);
    repeat (5) @(negedge CLK);
    check("single_done", 32'(done_count - dc), 32'd1);
    mem_delay = 1;

    repeat (5) @(negedge CLK);
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
